// File: rtl/serial_arb_pkg.sv
// serial_arb_pkg: shared state encoding and index sizing for the serial arbiters
package serial_arb_pkg;
  typedef enum logic [1:0] {SELECT, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first asserted request at or above ptr, wrapping around
module rr_pick import serial_arb_pkg::*; #(
  parameter int N = 4,
  parameter int W = id_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);
  logic [W-1:0] k;
  // walk N slots from ptr, keeping the first hit
  always_comb begin
    idx = '0;
    found = 1'b0;
    k = ptr;
    for (int i = 0; i < N; i++) begin
      if (!found && req[k]) begin
        idx = k;
        found = 1'b1;
      end
      k = (k == W'(N - 1)) ? '0 : k + 1'b1;
    end
  end
endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin, packet-locking share of one serial_tx
module serial_tx_arbiter import serial_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int REQ_ID_W = 2,
  parameter int LOCK_TIMEOUT = 1000,
  parameter int TO_CTR_SIZE = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*8-1:0]  req_data,
  input  logic [NUM_REQ-1:0]    req_last,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  pause,
  output logic [7:0]            tx_data,
  output logic                  tx_new_data,
  output logic                  tx_block,
  input  logic                  tx_busy,
  output logic [REQ_ID_W-1:0]   grant_id,
  output logic                  locked
);
  state_t state, state_nx;
  logic [REQ_ID_W-1:0] ptr, pick, win, ptr_nx;
  logic [TO_CTR_SIZE-1:0] to_cnt;
  logic found, cand, issue, stall, expire;

  assign tx_block = pause;

  rr_pick #(.N(NUM_REQ), .W(REQ_ID_W)) u_pick (
    .req(req_valid),
    .ptr(ptr),
    .idx(pick),
    .found(found)
  );

  // a locked owner is the only candidate; otherwise the rr search decides
  always_comb begin
    win = locked ? grant_id : pick;
    cand = locked ? req_valid[grant_id] : found;
    issue = (state == SELECT) && !tx_busy && !pause && cand;
    stall = (state == SELECT) && locked && !req_valid[grant_id] && !pause;
    expire = stall && (to_cnt == TO_CTR_SIZE'(LOCK_TIMEOUT - 1));
    ptr_nx = (win == REQ_ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    req_ready = issue ? (NUM_REQ'(1) << win) : '0;
  end

  // handshake sequencing: a refused pulse (busy never rose) is re-issued
  always_comb begin
    state_nx = state;
    case (state)
      SELECT:    state_nx = issue ? ISSUE : SELECT;
      ISSUE:     state_nx = WAIT_BUSY;
      WAIT_BUSY: state_nx = tx_busy ? WAIT_DONE : ISSUE;
      WAIT_DONE: state_nx = tx_busy ? WAIT_DONE : SELECT;
      default:   state_nx = SELECT;
    endcase
  end

  // state, captured byte, ownership and lock-stall timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SELECT;
      tx_new_data <= 1'b0;
      tx_data <= '0;
      grant_id <= '0;
      locked <= 1'b0;
      ptr <= '0;
      to_cnt <= '0;
    end else begin
      state <= state_nx;
      tx_new_data <= (state_nx == ISSUE);
      if (issue) begin
        tx_data <= req_data[8*win +: 8];
        grant_id <= win;
        locked <= !req_last[win];
        if (req_last[win]) ptr <= ptr_nx;
        to_cnt <= '0;
      end else if (expire) begin
        locked <= 1'b0;
        ptr <= ptr_nx;
        to_cnt <= '0;
      end else if (stall) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter: directed table, corner sequences and random run against a reference model
module tb_serial_tx_arbiter;
  localparam int NREQ = 4;
  localparam int LT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*8-1:0] req_data = '0;
  logic [NREQ-1:0] req_last = '0;
  logic [NREQ-1:0] req_ready;
  logic pause = 1'b0;
  logic [7:0] tx_data;
  logic tx_new_data, tx_block;
  logic tx_busy;
  logic [1:0] grant_id;
  logic locked;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_tx_arbiter #(.NUM_REQ(NREQ), .REQ_ID_W(2), .LOCK_TIMEOUT(LT), .TO_CTR_SIZE(10)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .pause(pause), .tx_data(tx_data), .tx_new_data(tx_new_data),
    .tx_block(tx_block), .tx_busy(tx_busy), .grant_id(grant_id), .locked(locked)
  );

  // behavioural serial_tx, 4 clocks per bit, 10-bit frame; block makes it ignore new_data
  logic stx_busy = 1'b0;
  int stx_cnt = 0;
  int stx_accepts = 0;
  logic [9:0] stx_sh = '1;
  logic [9:0] rx_bits = '0;
  logic stx_line;
  assign stx_line = stx_busy ? stx_sh[stx_cnt/4] : 1'b1;
  assign tx_busy = stx_busy;

  always @(posedge clk) begin
    if (rst) begin
      stx_busy <= 1'b0;
      stx_cnt <= 0;
    end else if (stx_busy) begin
      if (stx_cnt % 4 == 2) rx_bits[stx_cnt/4] <= stx_line;
      if (stx_cnt == 39) stx_busy <= 1'b0;
      stx_cnt <= stx_cnt + 1;
    end else if (tx_new_data && !tx_block) begin
      stx_busy <= 1'b1;
      stx_sh <= {1'b1, tx_data, 1'b0};
      stx_cnt <= 0;
      stx_accepts <= stx_accepts + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: arbitration rules applied per cycle, bytes scoreboarded against the line
  logic [7:0] sb[$];
  bit m_inflight = 0, m_seen = 0, m_locked = 0, m_prev = 0, m_issue, m_found;
  int m_owner = 0, m_ptr = 0, m_stall = 0, m_w;
  logic [NREQ-1:0] m_exp;
  logic [7:0] exp_b;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      m_inflight = 0; m_seen = 0; m_locked = 0; m_prev = 0;
      m_owner = 0; m_ptr = 0; m_stall = 0;
      sb.delete();
    end else begin
      m_found = 0;
      m_w = 0;
      if (m_locked) begin
        m_found = req_valid[m_owner];
        m_w = m_owner;
      end else begin
        for (int j = 0; j < NREQ; j++) begin
          if (req_valid[(m_ptr + j) % NREQ]) begin
            m_found = 1;
            m_w = (m_ptr + j) % NREQ;
            break;
          end
        end
      end
      m_issue = !m_inflight && !tx_busy && !pause && m_found;
      m_exp = m_issue ? NREQ'(1) << m_w : '0;
      chk("ready", req_ready, m_exp);
      chk("locked", locked, m_locked);
      chk("grant_id", grant_id, m_owner);
      if (m_prev) chk("new_data", tx_new_data, 1);
      if (stx_busy && stx_cnt == 39) begin
        exp_b = 'x;
        if (sb.size() != 0) exp_b = sb.pop_front();
        chk("start_bit", rx_bits[0], 0);
        chk("stop_bit", rx_bits[9], 1);
        chk("tx_byte", rx_bits[8:1], exp_b);
      end
      if (m_issue) begin
        sb.push_back(req_data[8*m_w +: 8]);
        m_owner = m_w;
        m_locked = !req_last[m_w];
        if (req_last[m_w]) m_ptr = (m_w + 1) % NREQ;
        m_stall = 0;
      end else if (!m_inflight && m_locked && !req_valid[m_owner] && !pause) begin
        m_stall++;
        if (m_stall == LT) begin
          m_locked = 0;
          m_ptr = (m_owner + 1) % NREQ;
          m_stall = 0;
        end
      end
      if (m_inflight) begin
        if (tx_busy) m_seen = 1;
        else if (m_seen) begin
          m_inflight = 0;
          m_seen = 0;
        end
      end
      if (m_issue) m_inflight = 1;
      m_prev = m_issue;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic [7:0] d;
    int win;
    bit lk;
  } vec_t;
  vec_t tbl[13];

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == 0 && n < 200);
  endtask

  task automatic settle();
    repeat (44) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic l);
    req_data[8*i +: 8] = d;
    req_last[i] = l;
  endtask

  int n, cnt, acc0;

  initial begin
    tbl[0]  = '{4'b0001, 4'b1111, 8'hA5, 0, 0};
    tbl[1]  = '{4'b1111, 4'b1111, 8'h10, 1, 0};
    tbl[2]  = '{4'b1111, 4'b1111, 8'h20, 2, 0};
    tbl[3]  = '{4'b1111, 4'b1111, 8'h30, 3, 0};
    tbl[4]  = '{4'b1111, 4'b1111, 8'h40, 0, 0};
    tbl[5]  = '{4'b0101, 4'b1111, 8'h50, 2, 0};
    tbl[6]  = '{4'b0011, 4'b0000, 8'h60, 0, 1};
    tbl[7]  = '{4'b1111, 4'b0000, 8'h70, 0, 1};
    tbl[8]  = '{4'b1111, 4'b0001, 8'h80, 0, 0};
    tbl[9]  = '{4'b1100, 4'b1111, 8'h90, 2, 0};
    tbl[10] = '{4'b0110, 4'b1111, 8'hA0, 1, 0};
    tbl[11] = '{4'b1000, 4'b0000, 8'hB0, 3, 1};
    tbl[12] = '{4'b1001, 4'b1000, 8'hC0, 3, 0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_new_data", tx_new_data, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_locked", locked, 0);
    @(posedge clk) #1;

    foreach (tbl[r]) begin
      req_valid = tbl[r].valid;
      req_last = tbl[r].last;
      for (int i = 0; i < NREQ; i++) req_data[8*i +: 8] = 8'(tbl[r].d + i);
      wait_ready(n);
      chk("tbl_ready", req_ready, NREQ'(1) << tbl[r].win);
      @(posedge clk) #1 req_valid = '0;
      @(negedge clk);
      chk("tbl_new_data", tx_new_data, 1);
      chk("tbl_tx_data", tx_data, 8'(tbl[r].d + tbl[r].win));
      chk("tbl_locked", locked, tbl[r].lk);
      chk("tbl_grant", grant_id, tbl[r].win);
      settle();
    end

    // packet lock: req 2 keeps the transmitter for three bytes while req 0 waits
    set_req(1, 8'h01, 1'b1);
    req_valid = 4'b0010;
    wait_ready(n);
    chk("pkt_pre", req_ready, 4'b0010);
    @(posedge clk) #1 req_valid = '0;
    settle();
    set_req(0, 8'h55, 1'b1);
    set_req(2, 8'h11, 1'b0);
    req_valid = 4'b0101;
    wait_ready(n);
    chk("pkt_b1", req_ready, 4'b0100);
    @(posedge clk) #1 set_req(2, 8'h22, 1'b0);
    @(negedge clk) chk("pkt_lock1", locked, 1);
    wait_ready(n);
    chk("pkt_b2", req_ready, 4'b0100);
    @(posedge clk) #1 set_req(2, 8'h33, 1'b1);
    @(negedge clk) chk("pkt_lock2", locked, 1);
    wait_ready(n);
    chk("pkt_b3", req_ready, 4'b0100);
    @(posedge clk) #1 req_valid[2] = 1'b0;
    @(negedge clk) chk("pkt_unlock", locked, 0);
    wait_ready(n);
    chk("pkt_req0", req_ready, 4'b0001);
    @(posedge clk) #1 req_valid = '0;
    settle();

    // lock timeout: req 1 stalls mid-packet, req 3 takes over after the timeout
    set_req(1, 8'h61, 1'b0);
    set_req(3, 8'h63, 1'b1);
    req_valid = 4'b1010;
    wait_ready(n);
    chk("to_first", req_ready, 4'b0010);
    @(posedge clk) #1 req_valid = 4'b1000;
    wait_ready(n);
    chk("to_gap", n, 59);
    chk("to_req3", req_ready, 4'b1000);
    chk("to_unlocked", locked, 0);
    @(posedge clk) #1 req_valid = '0;
    settle();
    set_req(1, 8'h62, 1'b1);
    req_valid = 4'b0010;
    wait_ready(n);
    chk("to_rearb", req_ready, 4'b0010);
    @(posedge clk) #1 req_valid = '0;
    settle();

    // pause raised in the ISSUE cycle: the byte is re-pulsed and accepted once
    acc0 = stx_accepts;
    set_req(0, 8'h3C, 1'b1);
    req_valid = 4'b0001;
    wait_ready(n);
    chk("pz_accept", req_ready, 4'b0001);
    @(posedge clk) #1;
    pause = 1'b1;
    req_valid = '0;
    repeat (10) @(posedge clk);
    #1 pause = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    chk("pz_once", stx_accepts - acc0, 1);

    // pause during WAIT_DONE: nothing is granted until pause falls
    set_req(1, 8'h7E, 1'b1);
    req_valid = 4'b0010;
    wait_ready(n);
    chk("pz2_accept", req_ready, 4'b0010);
    @(posedge clk) #1 req_valid = '0;
    repeat (10) @(posedge clk);
    #1;
    pause = 1'b1;
    req_valid = 4'b1111;
    req_last = 4'b1111;
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (req_ready != 0) cnt++;
    end
    chk("pz2_hold", cnt, 0);
    @(posedge clk) #1 pause = 1'b0;
    wait_ready(n);
    chk("pz2_release", req_ready, 4'b0100);
    @(posedge clk) #1 req_valid = '0;
    settle();

    // reset in the data bits of a locked packet
    set_req(2, 8'hC3, 1'b0);
    req_valid = 4'b0100;
    wait_ready(n);
    chk("rm_accept", req_ready, 4'b0100);
    @(posedge clk) #1 req_valid = '0;
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk) #1 rst = 1'b0;
    @(negedge clk);
    chk("rm_locked", locked, 0);
    chk("rm_grant", grant_id, 0);
    chk("rm_tx_data", tx_data, 0);
    chk("rm_new_data", tx_new_data, 0);
    @(posedge clk) #1;
    req_valid = 4'b1111;
    req_last = 4'b1111;
    wait_ready(n);
    chk("rm_from0", req_ready, 4'b0001);
    @(posedge clk) #1 req_valid = '0;
    settle();

    // random traffic, checked by the reference model
    for (int c = 0; c < 6000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(11) == 0) req_valid[i] = !req_valid[i];
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i] = ($urandom_range(2) == 0);
      end
      if (pause) pause = ($urandom_range(9) != 0);
      else pause = ($urandom_range(199) == 0);
      @(posedge clk) #1;
    end
    req_valid = '0;
    pause = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
- Shares one serial_tx instance between NUM_REQ byte producers (debug console, status reporter, etc.) using round-robin arbitration.
- Supports packet locking: once a requester wins, it keeps the transmitter until it sends a byte flagged last.
- Sequences the serial_tx new_data/busy handshake so that no byte is dropped and no frame is double-issued.
- Sits directly between the requesters and serial_tx, and drives all of serial_tx's control inputs.

Parameters:
- NUM_REQ, 4, number of requesters.
- REQ_ID_W, 2, width of the requester index; must be at least ceil(log2(NUM_REQ)).
- LOCK_TIMEOUT, 1000, idle cycles a locked owner may stall mid-packet before its lock is revoked.
- TO_CTR_SIZE, 10, width of the timeout counter; must hold LOCK_TIMEOUT.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester byte available.
- req_data  in  NUM_REQ*8  byte for requester i on bits [8i+7:8i].
- req_last  in  NUM_REQ  byte is the final byte of its packet.
- req_ready  out  NUM_REQ  one-hot acceptance strobe; a transfer happens on the cycle where valid and ready are both high.
- pause  in  1  global hold; forwarded to serial_tx block and stops new issues.
- tx_data  out  8  to serial_tx data.
- tx_new_data  out  1  to serial_tx new_data; one-cycle pulse.
- tx_block  out  1  to serial_tx block; equals pause combinationally.
- tx_busy  in  1  from serial_tx busy.
- grant_id  out  REQ_ID_W  index of the current or last owner.
- locked  out  1  a packet is in progress.

Behaviour:
- Reset values: state SELECT, tx_new_data=0, tx_data=0, req_ready=0, grant_id=0, locked=0, rr pointer=0, timeout counter=0.
- req_ready is combinational from the state registers and inputs. All other outputs are registered.
- SELECT state, issue condition: tx_busy=0, pause=0, and a candidate exists.
  - If locked: the candidate is grant_id when its valid is high.
  - If unlocked: the candidate is the first requester with valid high, searching from the rr pointer upward with wrap-around.
- SELECT state, on issue:
  - req_ready[w]=1 for that cycle only.
  - Capture req_data[w] into tx_data and set grant_id=w.
  - locked is set to !req_last[w].
  - If req_last[w]=1, the rr pointer becomes (w+1) mod NUM_REQ.
  - Go to ISSUE.
- SELECT state, lock stall: while locked and req_valid[grant_id]=0, increment the timeout counter.
  - When it reaches LOCK_TIMEOUT-1: clear locked, set rr pointer to grant_id+1 mod NUM_REQ, clear the counter.
  - The counter also clears on every issue.
  - While locked, other requesters' valid is ignored.
- ISSUE state: tx_new_data=1 for exactly one cycle, then go to WAIT_BUSY.
- WAIT_BUSY state:
  - tx_busy=1: go to WAIT_DONE.
  - tx_busy=0 (serial_tx refused the byte because block was set): return to ISSUE and re-pulse with the same tx_data. The byte is never lost.
- WAIT_DONE state: tx_new_data=0. When tx_busy=0, go to SELECT.
- Latency:
  - Acceptance to tx_new_data: 1 cycle.
  - Minimum spacing between req_ready strobes is one full frame plus 3 cycles.
- pause raised in any state: the frame in flight completes, and SELECT issues nothing further while pause is held. pause does not advance the timeout counter.
- Simultaneous events:
  - Valid from several requesters: the rr order decides.
  - Timeout expiry in the same cycle the owner's valid returns: the owner wins (issue takes priority, no revoke).
- rst mid-frame: the arbiter returns to SELECT and the lock is dropped. serial_tx is reset by the same rst, so no partial frame is tracked.
- NUM_REQ=1 must work: the pointer stays 0.

Decomposition:
- Package serial_arb_pkg: state encoding (SELECT, ISSUE, WAIT_BUSY, WAIT_DONE as a 2-bit enum) and a helper function for the requester-index width.
- Sub-module rr_pick: combinational.
  - Inputs: request vector and pointer.
  - Outputs: winner index and found flag.
  - Reused by later arbiters (serial_rx fan-out, SPI).

Test Plan (bench instantiates serial_tx with CLK_PER_BIT=4, so a frame is 40 cycles):
- Single byte: req 0 sends 0xA5, last=1. Expect req_ready[0] for 1 cycle and tx_new_data 1 cycle later. tx shows start bit, 1,0,1,0,0,1,0,1, stop bit. The pointer moves to 1.
- Fairness: reqs 0–3 all valid with last=1 on every byte. Expected grant order is 0,1,2,3,0, one byte each, each strobe at least 43 cycles apart.
- Packet lock: req 2 sends 0x11, 0x22, 0x33 with last on 0x33 while req 0 is continuously valid. All three req 2 bytes go out before req 0's byte. locked=1 until 0x33 is accepted.
- Lock timeout (LOCK_TIMEOUT=16): req 1 sends 1 byte with last=0, then drops valid.
  - After WAIT_DONE plus 16 cycles, locked=0 and req 3 (valid) is granted.
  - When req 1 later presents a byte with last=1, it re-arbitrates normally.
- Pause and re-issue: assert pause in the same cycle as ISSUE. The byte must still appear exactly once on tx, with no extra new_data accepted. Assert pause during WAIT_DONE and hold it for 100 cycles: no req_ready until pause falls.
- Reset mid-packet: apply rst during the DATA bits of a locked packet. Outputs return to reset values, locked=0, and the next arbitration starts from requester 0.
